// File: rtl/complement_gate_mw.sv
// Early-bus OR merge plus serial sign/complement gate onto the intermediate bus, multi-word operands.
// Latency: EB/IB combinational (zero); neg/state/z one clock; mz/fo one clock after the last bit.
// Backpressure: none; a bit-serial stream, xfer=0 gates IB to 0 and abandons the operand.
//
// Ports:
//   CLOCK, rst        bit clock, synchronous active-low reset
//   eb_src            early-bus source lines, OR-merged onto EB
//   TS, op_start      sign-bit time strobe; op_start marks word 0 of an operand
//   xfer, mode        transfer enable; 00 pass, 01 SM->2C, 10 2C->SM, 11 SM negate
//   nwords            operand length in words (0 -> 1, clamped to MAX_WORDS)
//   ovf_in, fo_clr    set / clear for the sticky overflow flag (set wins)
//   EB, IB            early bus, intermediate bus
//   neg, fo, mz       latched operand sign, sticky overflow, minus-zero pulse
module complement_gate_mw #(
    parameter int NSRC      = 31,
    parameter int WORD_BITS = 29,
    parameter int MAX_WORDS = 2,
    parameter int NW_W      = $clog2(MAX_WORDS) + 1
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic [NSRC-1:0] eb_src,
    input  logic            TS,
    input  logic            op_start,
    input  logic            xfer,
    input  logic [1:0]      mode,
    input  logic [NW_W-1:0] nwords,
    input  logic            ovf_in,
    input  logic            fo_clr,
    output logic            EB,
    output logic            IB,
    output logic            neg,
    output logic            fo,
    output logic            mz
);

    localparam int              BC_W      = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_BITS - 1);
    localparam logic [NW_W-1:0] WORDS_MAX = NW_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS   = 2'd1,
        INVERT = 2'd2
    } state_t;

    state_t          state;
    logic [BC_W-1:0] bitcnt;
    logic [NW_W-1:0] wordcnt;
    logic [NW_W-1:0] wordcnt_nxt;
    logic [NW_W-1:0] n_eff;
    logic [NW_W-1:0] w_last;
    logic            z;
    logic            w0t0;
    logic            last_bit;
    logic            converting;
    logic            mz_set;

    assign EB = |eb_src;

    // Effective operand length: 0 behaves as a single word, oversize is clamped.
    always_comb begin
        n_eff = nwords;
        if (nwords == '0) begin
            n_eff = NW_W'(1);
        end else if (nwords > WORDS_MAX) begin
            n_eff = WORDS_MAX;
        end
    end

    assign w_last = n_eff - NW_W'(1);

    // The >= compare lets the post-reset value (MAX_WORDS-1) wrap cleanly even
    // when the current operand is shorter than MAX_WORDS.
    always_comb begin
        wordcnt_nxt = wordcnt;
        if (TS && op_start) begin
            wordcnt_nxt = '0;
        end else if (TS) begin
            wordcnt_nxt = (wordcnt >= w_last) ? '0 : wordcnt + 1'b1;
        end
    end

    // Sign bit of word 0; every other bit, including TS of later words, is magnitude.
    assign w0t0       = TS && (wordcnt_nxt == '0);
    assign last_bit   = (wordcnt == w_last) && (bitcnt == BIT_LAST);
    assign converting = ((mode == 2'b01) || (mode == 2'b10)) && neg;

    // Minus-zero: negative sign with an all-zero magnitude, including the last bit itself.
    assign mz_set = (state != IDLE) && xfer && last_bit && converting && z && !EB;

    // Serial two's complement: PASS lets the first 1 through, INVERT flips everything after it.
    always_comb begin
        IB = 1'b0;
        if (rst && xfer) begin
            if (w0t0) begin
                IB = (mode == 2'b11) ? ~EB : EB;
            end else if (state == INVERT) begin
                IB = ~EB;
            end else begin
                IB = EB;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state   <= IDLE;
            neg     <= 1'b0;
            fo      <= 1'b0;
            mz      <= 1'b0;
            z       <= 1'b0;
            bitcnt  <= '0;
            wordcnt <= NW_W'(MAX_WORDS - 1);
        end else begin
            // TS always resynchronises the bit counter, whatever the current count.
            if (TS) begin
                bitcnt <= BC_W'(1);
            end else if (bitcnt == BIT_LAST) begin
                bitcnt <= '0;
            end else begin
                bitcnt <= bitcnt + 1'b1;
            end
            wordcnt <= wordcnt_nxt;

            if (!xfer) begin
                state <= IDLE;
            end else if (w0t0) begin
                state <= PASS;
                neg   <= EB;
            end else if ((state != IDLE) && last_bit) begin
                state <= IDLE;
            end else if ((state == PASS) && converting && EB) begin
                state <= INVERT;
            end

            if (w0t0) begin
                if (xfer) begin
                    z <= 1'b1;
                end
            end else if (EB) begin
                z <= 1'b0;
            end

            mz <= mz_set;

            // -2^n has no sign-magnitude form, so a minus-zero in 2C->SM is an overflow.
            if (ovf_in || (mz_set && (mode == 2'b10))) begin
                fo <= 1'b1;
            end else if (fo_clr) begin
                fo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_complement_gate_mw.sv
module tb_complement_gate_mw;

    localparam int NSRC = 31;
    localparam int WB   = 29;
    localparam int MAXW = 2;
    localparam int NW_W = 2;

    logic            CLOCK = 1'b0;
    logic            rst;
    logic [NSRC-1:0] eb_src;
    logic            TS;
    logic            op_start;
    logic            xfer;
    logic [1:0]      mode;
    logic [NW_W-1:0] nwords;
    logic            ovf_in;
    logic            fo_clr;
    logic            EB;
    logic            IB;
    logic            neg;
    logic            fo;
    logic            mz;

    always #5 CLOCK = ~CLOCK;

    complement_gate_mw #(
        .NSRC     (NSRC),
        .WORD_BITS(WB),
        .MAX_WORDS(MAXW),
        .NW_W     (NW_W)
    ) dut (
        .CLOCK   (CLOCK),
        .rst     (rst),
        .eb_src  (eb_src),
        .TS      (TS),
        .op_start(op_start),
        .xfer    (xfer),
        .mode    (mode),
        .nwords  (nwords),
        .ovf_in  (ovf_in),
        .fo_clr  (fo_clr),
        .EB      (EB),
        .IB      (IB),
        .neg     (neg),
        .fo      (fo),
        .mz      (mz)
    );

    typedef struct {
        logic ib;
        logic eb;
        logic neg;
        logic fo;
        logic mz;
    } exp_t;

    exp_t sb[$];

    // Reference-model state: what the registered outputs should show during the next cycle.
    bit       neg_m = 1'b0;
    bit       fo_m  = 1'b0;
    bit       mz_m  = 1'b0;
    bit [1:0] cur_mode = 2'd0;
    bit [1:0] cur_nw   = 2'd1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic act, input logic want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, want);
        end
    endtask

    // Monitor: every cycle with a queued expectation, compare the bus and flags.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("IB",  IB,  e.ib);
                chk("EB",  EB,  e.eb);
                chk("neg", neg, e.neg);
                chk("fo",  fo,  e.fo);
                chk("mz",  mz,  e.mz);
            end
        end
    end

    // Drive one bit time, queue its expectation, then advance the model past the clock edge.
    task automatic step(input bit r, input bit ebit, input bit ts, input bit ops,
                        input bit xf, input bit [1:0] md, input bit [1:0] nw,
                        input bit ovf, input bit fclr, input bit exp_ib,
                        input bit mz_evt, input bit latch, input bit sgn);
        exp_t            e;
        logic [NSRC-1:0] v;
        @(posedge CLOCK);
        #1;
        v = NSRC'($urandom);
        if (ebit) v[$urandom_range(NSRC-1, 0)] = 1'b1;
        else      v = '0;
        rst      = r;
        eb_src   = v;
        TS       = ts;
        op_start = ops;
        xfer     = xf;
        mode     = md;
        nwords   = nw;
        ovf_in   = ovf;
        fo_clr   = fclr;
        e.ib  = r ? exp_ib : 1'b0;
        e.eb  = ebit;
        e.neg = neg_m;
        e.fo  = fo_m;
        e.mz  = mz_m;
        sb.push_back(e);
        if (!r) begin
            neg_m = 1'b0;
            fo_m  = 1'b0;
            mz_m  = 1'b0;
        end else begin
            mz_m = mz_evt;
            if (ovf || (mz_evt && md == 2'd2)) fo_m = 1'b1;
            else if (fclr)                     fo_m = 1'b0;
            if (latch) neg_m = sgn;
        end
    endtask

    // Idle bit times between operands: no TS, so IB just follows EB when xfer is high.
    task automatic gap(input int k, input bit allow_fo);
        bit xf, ebit, ovf, fclr;
        for (int c = 0; c < k; c++) begin
            xf   = 1'($urandom_range(0, 1));
            ebit = 1'($urandom_range(0, 1));
            ovf  = allow_fo && ($urandom_range(0, 7) == 0);
            fclr = allow_fo && ($urandom_range(0, 3) == 0);
            step(1'b1, ebit, 1'b0, 1'b0, xf, cur_mode, cur_nw, ovf, fclr,
                 xf & ebit, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic fo_step(input bit ovf, input bit fclr);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur_mode, cur_nw, ovf, fclr,
             1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One operand. Expected IB comes from arithmetic on the whole word:
    // converting negates the magnitude modulo 2^(bits-1), mode 11 flips the sign.
    task automatic run_operand(input bit [1:0] md, input bit [1:0] nw_in, input bit sgn,
                               input logic [63:0] mag_in, input int drop_at, input int rst_at);
        int          n, len;
        logic [63:0] mask, mag, mo;
        bit          conv, so, xf, ebit, ib, mzev, stop;
        n    = (nw_in == 0) ? 1 : ((nw_in > MAXW) ? MAXW : int'(nw_in));
        len  = n * WB;
        mask = (64'd1 << (len - 1)) - 64'd1;
        mag  = mag_in & mask;
        conv = ((md == 2'd1) || (md == 2'd2)) && sgn;
        mo   = conv ? ((~mag + 64'd1) & mask) : mag;
        so   = (md == 2'd3) ? ~sgn : sgn;
        cur_mode = md;
        cur_nw   = nw_in;
        stop = 1'b0;
        for (int i = 0; i < len && !stop; i++) begin
            if (rst_at >= 0 && i == rst_at) begin
                for (int k = 0; k < 3; k++)
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, md, nw_in,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                stop = 1'b1;
            end else begin
                xf   = !(drop_at >= 0 && i >= drop_at);
                ebit = (i == 0) ? sgn : mag[i-1];
                ib   = xf & ((i == 0) ? so : mo[i-1]);
                mzev = (i == len - 1) && xf && conv && (mag == 64'd0);
                step(1'b1, ebit, (i % WB) == 0, i == 0, xf, md, nw_in, 1'b0, 1'b0,
                     ib, mzev, (i == 0) && xf, sgn);
            end
        end
    endtask

    initial begin
        bit [1:0]    md, nw;
        bit          sgn;
        logic [63:0] mag;
        int          drop;

        rst = 1'b0; eb_src = '0; TS = 1'b0; op_start = 1'b0; xfer = 1'b0;
        mode = 2'd0; nwords = 2'd1; ovf_in = 1'b0; fo_clr = 1'b0;

        // Reset held with traffic present: IB gated, flags cleared, EB still live.
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
                 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        gap(3, 1'b0);

        // Directed operands.
        run_operand(2'd1, 2'd1, 1'b1, 64'd6, -1, -1);   // SM->2C of -6
        run_operand(2'd1, 2'd1, 1'b0, 64'd6, -1, -1);   // positive: pass through
        run_operand(2'd2, 2'd2, 1'b1, 64'd0, -1, -1);   // minus-zero, sets fo
        gap(2, 1'b0);
        fo_step(1'b1, 1'b1);                             // set beats clear
        fo_step(1'b0, 1'b1);                             // clear alone
        fo_step(1'b0, 1'b0);
        run_operand(2'd3, 2'd1, 1'b0, 64'd5, 10, -1);   // negate, xfer dropped at bit 10
        gap(2, 1'b0);

        // Randomised operands, back-to-back or with gaps.
        for (int t = 0; t < 40; t++) begin
            md   = 2'($urandom_range(0, 3));
            nw   = 2'($urandom_range(0, 3));
            sgn  = 1'($urandom_range(0, 1));
            mag  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) mag = 64'd0;
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 57)) : -1;
            run_operand(md, nw, sgn, mag, drop, -1);
            if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 4)), 1'b1);
        end

        // Reset in the middle of a minus-zero operand: no mz and no fo may follow.
        run_operand(2'd2, 2'd2, 1'b1, 64'd0, -1, 40);
        gap(3, 1'b0);
        run_operand(2'd1, 2'd1, 1'b1, 64'd6, -1, -1);
        gap(2, 1'b0);

        repeat (3) @(posedge CLOCK);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
